// File: rtl/lcd_i2c_sequencer.sv
// HD44780 (4-bit mode) sequencer behind a PCF8574 expander: runs the power-up/init
// list, then turns each accepted LCD byte into four single-byte I2C write requests.
module lcd_i2c_sequencer #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter logic [7:0]  I2C_ADDR = 8'h4E,
  parameter int unsigned PWRUP_US = 40000,
  parameter int unsigned SHORT_US = 50,
  parameter int unsigned LONG_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       backlight,
  output logic       init_done,
  output logic [7:0] i2c_address,
  output logic [7:0] i2c_data,
  output logic [7:0] i2c_length,
  output logic       i2c_do_not_end,
  output logic       i2c_start,
  input  logic       i2c_busy
);

  localparam int unsigned CYC_PER_US = CLK_HZ / 1000000;
  localparam logic [31:0] PWRUP_CYC =
    (CYC_PER_US * PWRUP_US == 0) ? 32'd1 : 32'(CYC_PER_US * PWRUP_US);
  localparam logic [31:0] SHORT_CYC =
    (CYC_PER_US * SHORT_US == 0) ? 32'd1 : 32'(CYC_PER_US * SHORT_US);
  localparam logic [31:0] LONG_CYC =
    (CYC_PER_US * LONG_US == 0) ? 32'd1 : 32'(CYC_PER_US * LONG_US);

  localparam logic [1:0] HI_EN1 = 2'd0;
  localparam logic [1:0] HI_EN0 = 2'd1;
  localparam logic [1:0] LO_EN0 = 2'd3;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_ARM,
    S_REQ,
    S_WAIT,
    S_DELAY
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [1:0]  step_reg, step_next;
  logic [7:0]  byte_reg, byte_next;
  logic        rs_reg, rs_next;
  logic        long_reg, long_next;
  logic        single_reg, single_next;
  logic [7:0]  data_reg, data_next;
  logic        init_done_reg, init_done_next;

  logic [3:0]  nibble;
  logic [7:0]  expander_byte;
  logic        last_step;

  // Init list entry as {single_nibble, long_delay, lcd_byte}; single nibbles use the high half.
  function automatic logic [9:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return {2'b11, 8'h30};
      3'd1:    return {2'b11, 8'h30};
      3'd2:    return {2'b10, 8'h30};
      3'd3:    return {2'b10, 8'h20};
      3'd4:    return {2'b00, 8'h28};
      3'd5:    return {2'b00, 8'h0C};
      3'd6:    return {2'b00, 8'h06};
      default: return {2'b01, 8'h01};
    endcase
  endfunction

  assign nibble        = step_reg[1] ? byte_reg[3:0] : byte_reg[7:4];
  assign expander_byte = {nibble, backlight, ~step_reg[0], 1'b0, rs_reg};
  assign last_step     = single_reg ? (step_reg == HI_EN0) : (step_reg == LO_EN0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_PWRUP;
      cnt_reg       <= PWRUP_CYC - 32'd1;
      idx_reg       <= '0;
      step_reg      <= HI_EN1;
      byte_reg      <= '0;
      rs_reg        <= 1'b0;
      long_reg      <= 1'b0;
      single_reg    <= 1'b0;
      data_reg      <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      step_reg      <= step_next;
      byte_reg      <= byte_next;
      rs_reg        <= rs_next;
      long_reg      <= long_next;
      single_reg    <= single_next;
      data_reg      <= data_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    step_next      = step_reg;
    byte_next      = byte_reg;
    rs_next        = rs_reg;
    long_next      = long_reg;
    single_next    = single_reg;
    data_next      = data_reg;
    init_done_next = init_done_reg;

    case (state_reg)
      S_PWRUP: begin
        if (cnt_reg == 32'd0) begin
          {single_next, long_next, byte_next} = init_entry(3'd0);
          idx_next   = 3'd0;
          rs_next    = 1'b0;
          step_next  = HI_EN1;
          state_next = S_ARM;
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          byte_next   = in_data;
          rs_next     = in_rs;
          long_next   = !in_rs && (in_data == 8'h01 || in_data == 8'h02 || in_data == 8'h03);
          single_next = 1'b0;
          step_next   = HI_EN1;
          state_next  = S_ARM;
        end
      end
      // Every transfer passes through ARM so a busy engine (even a stray one) blocks the start.
      S_ARM: begin
        if (!i2c_busy) begin
          data_next  = expander_byte;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (i2c_busy) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i2c_busy) begin
          if (last_step) begin
            cnt_next   = (long_reg ? LONG_CYC : SHORT_CYC) - 32'd1;
            state_next = S_DELAY;
          end else begin
            step_next  = step_reg + 2'd1;
            state_next = S_ARM;
          end
        end
      end
      S_DELAY: begin
        if (cnt_reg != 32'd0) begin
          cnt_next = cnt_reg - 32'd1;
        end else if (init_done_reg) begin
          state_next = S_IDLE;
        end else if (idx_reg == 3'd7) begin
          init_done_next = 1'b1;
          state_next     = S_IDLE;
        end else begin
          {single_next, long_next, byte_next} = init_entry(idx_reg + 3'd1);
          idx_next   = idx_reg + 3'd1;
          rs_next    = 1'b0;
          step_next  = HI_EN1;
          state_next = S_ARM;
        end
      end
      default: state_next = S_PWRUP;
    endcase
  end

  assign in_ready       = (state_reg == S_IDLE);
  assign i2c_start      = (state_reg == S_REQ);
  assign i2c_data       = data_reg;
  assign init_done      = init_done_reg;
  assign i2c_address    = I2C_ADDR;
  assign i2c_length     = 8'd1;
  assign i2c_do_not_end = 1'b0;

endmodule

// File: tb/tb_lcd_i2c_sequencer.sv
// Scoreboard bench: stimulus pushes expected expander bytes and post-transfer gaps,
// a negedge busy-model/monitor pops and compares each I2C request as it appears.
module tb_lcd_i2c_sequencer;

  localparam int unsigned CLK_HZ   = 1000000;
  localparam int unsigned PWRUP_US = 300;
  localparam int unsigned SHORT_US = 20;
  localparam int unsigned LONG_US  = 150;
  localparam int CPU       = CLK_HZ / 1000000;
  localparam int PWRUP_CYC = PWRUP_US * CPU;
  localparam int SHORT_CYC = SHORT_US * CPU;
  localparam int LONG_CYC  = LONG_US * CPU;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic       in_valid = 1'b0;
  logic       backlight = 1'b1;
  logic       busy = 1'b0;
  logic       in_ready, init_done, i2c_do_not_end, i2c_start;
  logic [7:0] i2c_address, i2c_data, i2c_length;

  lcd_i2c_sequencer #(
    .CLK_HZ(CLK_HZ), .I2C_ADDR(8'h4E), .PWRUP_US(PWRUP_US),
    .SHORT_US(SHORT_US), .LONG_US(LONG_US)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_rs(in_rs), .in_valid(in_valid),
    .in_ready(in_ready), .backlight(backlight), .init_done(init_done),
    .i2c_address(i2c_address), .i2c_data(i2c_data), .i2c_length(i2c_length),
    .i2c_do_not_end(i2c_do_not_end), .i2c_start(i2c_start), .i2c_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gmin;
    int         gmax;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rise_dly = 3;
  int   hold_cyc = 100;
  int   xfer_count = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference model: LCD execution delay rule and nibble-to-expander-byte arithmetic.
  function automatic int delay_for(input logic [7:0] b, input logic rs);
    return (!rs && b >= 8'd1 && b <= 8'd3) ? LONG_CYC : SHORT_CYC;
  endfunction

  task automatic push_lcd(input logic [7:0] b, input logic rs, input logic bl,
                          input bit single_nib, input int dly);
    int nibs[$];
    nibs.push_back(int'(b) / 16);
    if (!single_nib) nibs.push_back(int'(b) % 16);
    foreach (nibs[i]) begin
      for (int en = 1; en >= 0; en--) begin
        exp_t e;
        bit   last;
        last   = (i == nibs.size() - 1) && (en == 0);
        e.data = 8'(nibs[i] * 16 + int'(bl) * 8 + en * 4 + int'(rs));
        e.gmin = last ? dly : 1;
        e.gmax = last ? dly + 3 : 3;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_init(input logic bl);
    logic [7:0] full_bytes[4];
    full_bytes = '{8'h28, 8'h0C, 8'h06, 8'h01};
    push_lcd(8'h30, 1'b0, bl, 1'b1, LONG_CYC);
    push_lcd(8'h30, 1'b0, bl, 1'b1, LONG_CYC);
    push_lcd(8'h30, 1'b0, bl, 1'b1, SHORT_CYC);
    push_lcd(8'h20, 1'b0, bl, 1'b1, SHORT_CYC);
    foreach (full_bytes[i]) push_lcd(full_bytes[i], 1'b0, bl, 1'b0, delay_for(full_bytes[i], 1'b0));
  endtask

  // Busy model and monitor: all sampling and driving happens on the falling edge.
  int         phase = 0;
  int         mcnt = 0;
  int         gap_cnt = 0;
  bit         gap_active = 0;
  bit         cur_valid = 0;
  bit         stable_ok = 0;
  bit         no_start_ok = 0;
  logic [7:0] held_data = 8'h00;
  exp_t       cur;

  always @(negedge clk) begin
    if (rst) begin
      cur_valid  = 0;
      gap_active = 0;
    end
    if (gap_active) begin
      gap_cnt++;
      if (i2c_start || in_ready) begin
        check(gap_cnt >= cur.gmin && gap_cnt <= cur.gmax, "post_xfer_gap", gap_cnt, cur.gmin);
        gap_active = 0;
      end else if (gap_cnt > 5000) begin
        check(0, "post_xfer_gap_timeout", gap_cnt, cur.gmax);
        gap_active = 0;
      end
    end
    case (phase)
      0: begin
        if (i2c_start) begin
          xfer_count++;
          if (exp_q.size() == 0) begin
            check(0, "unexpected_start", i2c_data, 0);
          end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1;
            check(i2c_data == cur.data, "xfer_data", i2c_data, cur.data);
            $display("xfer %0d: i2c_data=0x%02h expected=0x%02h", xfer_count, i2c_data, cur.data);
          end
          held_data = i2c_data;
          stable_ok = 1;
          mcnt      = rise_dly;
          phase     = 1;
        end
      end
      1: begin
        if (!i2c_start || i2c_data !== held_data) stable_ok = 0;
        mcnt--;
        if (mcnt <= 0) begin
          check(stable_ok, "start_held_until_busy", i2c_data, held_data);
          busy        = 1'b1;
          no_start_ok = 1;
          mcnt        = hold_cyc;
          phase       = 2;
        end
      end
      default: begin
        if (i2c_start) no_start_ok = 0;
        mcnt--;
        if (mcnt <= 0) begin
          busy = 1'b0;
          check(no_start_ok, "no_start_while_busy", 1, 0);
          if (cur_valid) begin
            gap_active = 1;
            gap_cnt    = 0;
          end
          cur_valid = 0;
          phase     = 0;
        end
      end
    endcase
  end

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!in_ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(in_ready == 1'b1, "ready_return", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input logic bl);
    backlight = bl;
    wait_ready(20000);
    push_lcd(b, rs, bl, 1'b0, delay_for(b, rs));
    in_data  = b;
    in_rs    = rs;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_rs    = 1'($urandom);
    check(in_ready == 1'b0, "ready_drop_after_accept", in_ready, 0);
    wait_ready(20000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t exceeded limit %0d", $time, 1000000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int xc0;
    push_init(1'b1);
    repeat (3) @(negedge clk);
    check(in_ready == 1'b0, "reset_in_ready", in_ready, 0);
    check(init_done == 1'b0, "reset_init_done", init_done, 0);
    check(i2c_start == 1'b0, "reset_i2c_start", i2c_start, 0);
    check(i2c_data == 8'h00, "reset_i2c_data", i2c_data, 0);
    check(i2c_address == 8'h4E, "i2c_address", i2c_address, 8'h4E);
    check(i2c_length == 8'd1, "i2c_length", i2c_length, 1);
    check(i2c_do_not_end == 1'b0, "i2c_do_not_end", i2c_do_not_end, 0);
    rst = 1'b0;

    k = 0;
    while (!i2c_start && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(k >= PWRUP_CYC && k <= PWRUP_CYC + 3, "pwrup_wait", k, PWRUP_CYC);
    check(init_done == 1'b0, "init_done_during_init", init_done, 0);
    wait_ready(20000);
    check(init_done == 1'b1, "init_done_after_init", init_done, 1);
    check(exp_q.size() == 0, "init_all_xfers", exp_q.size(), 0);

    send_byte(8'h41, 1'b1, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      logic [7:0] b;
      logic       rs;
      logic       bl;
      b  = 8'($urandom);
      rs = 1'($urandom);
      bl = 1'($urandom);
      if (r == 1) begin
        rs = 1'b0;
        b  = 8'($urandom_range(3, 1));
      end
      send_byte(b, rs, bl);
    end

    // Two bytes back to back with in_valid held high throughout.
    backlight = 1'b1;
    wait_ready(20000);
    xc0 = xfer_count;
    push_lcd(8'h48, 1'b1, 1'b1, 1'b0, delay_for(8'h48, 1'b1));
    push_lcd(8'h02, 1'b0, 1'b1, 1'b0, delay_for(8'h02, 1'b0));
    in_data  = 8'h48;
    in_rs    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h02;
    in_rs   = 1'b0;
    k = 0;
    while (!in_ready && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(in_ready == 1'b1, "b2b_second_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check(in_ready == 1'b0, "b2b_second_accepted", in_ready, 0);
    wait_ready(20000);
    check(xfer_count - xc0 == 8, "b2b_xfer_count", xfer_count - xc0, 8);

    // Slow engine: start and data must sit still for 500 cycles before busy rises.
    rise_dly = 500;
    send_byte(8'hA7, 1'b1, 1'($urandom));
    rise_dly = 3;

    // Reset while the engine is busy; restart must wait out both PWRUP and busy.
    hold_cyc = 400;
    backlight = 1'b1;
    wait_ready(20000);
    push_lcd(8'h55, 1'b1, 1'b1, 1'b0, SHORT_CYC);
    in_data  = 8'h55;
    in_rs    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!(busy && !i2c_start) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(busy == 1'b1, "reset_test_busy_reached", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    push_init(1'b1);
    @(negedge clk);
    check(i2c_start == 1'b0, "midrst_i2c_start", i2c_start, 0);
    check(in_ready == 1'b0, "midrst_in_ready", in_ready, 0);
    check(init_done == 1'b0, "midrst_init_done", init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!i2c_start && k < 5000) begin
      @(negedge clk);
      k++;
    end
    hold_cyc = 100;
    check(k >= PWRUP_CYC, "restart_pwrup_wait", k, PWRUP_CYC);
    check(i2c_start && busy == 1'b0, "restart_waits_busy", busy, 0);
    wait_ready(20000);
    check(init_done == 1'b1, "reinit_done", init_done, 1);

    send_byte(8'h3F, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
